// File: rtl/imm_pkg.sv
// Shared types, opcode constants and the pure immediate-extract helpers
// used by the decode-stage immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_type_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_FULL1 = 2'b10,
        BUF_FULL2 = 2'b11
    } buf_state_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] SEL_ILLEGAL = 3'b111;
    localparam int unsigned XLEN_MAX   = 64;

    function automatic logic imm_legal(input logic [2:0] sel);
        return sel <= 3'(IMM_J);
    endfunction

    function automatic logic [2:0] opcode_to_sel(input logic [6:0] op);
        logic [2:0] sel;
        sel = SEL_ILLEGAL;
        unique case (op)
            OP_IMM, OP_LOAD,
            OP_JALR, OP_SYSTEM: sel = IMM_I;
            OP_STORE:           sel = IMM_S;
            OP_BRANCH:          sel = IMM_B;
            OP_LUI, OP_AUIPC:   sel = IMM_U;
            OP_JAL:             sel = IMM_J;
            default:            sel = SEL_ILLEGAL;
        endcase
        return sel;
    endfunction

    // Full-width result; callers keep the low XLEN bits, which is
    // exactly the sign extension to XLEN.
    function automatic logic [XLEN_MAX-1:0] imm_extract(
        input logic [31:0] inst,
        input logic [2:0]  sel
    );
        logic [XLEN_MAX-1:0] s;
        logic [XLEN_MAX-1:0] imm;
        s   = {XLEN_MAX{inst[31]}};
        imm = '0;
        unique case (sel)
            IMM_I: imm = {s[63:12], inst[31:20]};
            IMM_S: imm = {s[63:12], inst[31:25], inst[11:7]};
            IMM_B: imm = {s[63:13], inst[31], inst[7],
                          inst[30:25], inst[11:8], 1'b0};
            IMM_U: imm = {s[63:32], inst[31:12], 12'b0};
            IMM_J: imm = {s[63:21], inst[31], inst[19:12],
                          inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_skid_buffer.sv
// Two-entry skid buffer: registered output and registered ready, so
// consumer back-pressure never reaches the producer combinationally.
module imm_skid_buffer
    import imm_pkg::*;
#(
    parameter int DATA_W = 65
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Flush,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [DATA_W-1:0] i_Data,
    output logic              o_Valid,
    input  logic              i_Ready,
    output logic [DATA_W-1:0] o_Data
);

    buf_state_e        state_q;
    buf_state_e        state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              ready_q;

    logic accept;
    logic xfer;
    logic main_ld;
    logic main_from_skid;
    logic skid_ld;

    assign accept = i_Valid & ready_q;
    assign xfer   = (state_q != BUF_EMPTY) & i_Ready;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        unique case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    state_d = BUF_FULL1;
                    main_ld = 1'b1;
                end
            end
            BUF_FULL1: begin
                if (accept && !xfer) begin
                    state_d = BUF_FULL2;
                    skid_ld = 1'b1;
                end else if (accept && xfer) begin
                    main_ld = 1'b1;
                end else if (xfer) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL2: begin
                if (xfer) begin
                    state_d        = BUF_FULL1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        // Flush overrides any concurrent accept or transfer.
        if (i_Flush) begin
            state_d        = BUF_EMPTY;
            main_ld        = 1'b0;
            main_from_skid = 1'b0;
            skid_ld        = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= BUF_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != BUF_FULL2);
            if (main_ld) begin
                main_q <= i_Data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (skid_ld) begin
                skid_q <= i_Data;
            end
        end
    end

    assign o_Ready = ready_q;
    assign o_Valid = (state_q != BUF_EMPTY);
    assign o_Data  = main_q;

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: selects the format, extracts and
// sign-extends the immediate, then registers it through a skid buffer.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 32,
    parameter int AUTO_DECODE = 0
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic [31:0]      i_Instruction,
    input  logic [2:0]       i_ImmSrc,
    input  logic [TAG_W-1:0] i_Tag,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic             i_Flush,
    output logic [XLEN-1:0]  o_ImmExt,
    output logic             o_Illegal,
    output logic [TAG_W-1:0] o_Tag,
    output logic             o_Valid,
    input  logic             i_Ready
);

    localparam int DATA_W = XLEN + 1 + TAG_W;

    logic [2:0]          sel;
    logic                illegal;
    logic [XLEN_MAX-1:0] imm_full;
    logic [DATA_W-1:0]   data_in;
    logic [DATA_W-1:0]   data_out;
    logic                unused_in;

    generate
        if (AUTO_DECODE != 0) begin : g_auto
            assign sel = opcode_to_sel(i_Instruction[6:0]);
        end else begin : g_src
            assign sel = i_ImmSrc;
        end
    endgenerate

    assign unused_in = ^{i_ImmSrc, i_Instruction[6:0]};

    assign illegal  = !imm_legal(sel);
    assign imm_full = imm_extract(i_Instruction, sel);

    generate
        if (XLEN < XLEN_MAX) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^imm_full[XLEN_MAX-1:XLEN];
        end
    endgenerate

    assign data_in = {imm_full[XLEN-1:0], illegal, i_Tag};

    imm_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_skid (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Flush (i_Flush),
        .i_Valid (i_Valid),
        .o_Ready (o_Ready),
        .i_Data  (data_in),
        .o_Valid (o_Valid),
        .i_Ready (i_Ready),
        .o_Data  (data_out)
    );

    assign o_ImmExt  = data_out[DATA_W-1 -: XLEN];
    assign o_Illegal = data_out[TAG_W];
    assign o_Tag     = data_out[TAG_W-1:0];

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three instances (32-bit, 64-bit, auto-decode)
// checked every cycle against a capacity-2 FIFO reference model.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = '0;
    logic [2:0]  src = '0;
    logic [31:0] tag = '0;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic        rdy = 1'b0;

    logic [31:0] imm32, tag32, imma, taga, tag64;
    logic [63:0] imm64;
    logic        ill32, v32, r32, ill64, v64, r64, illa, va, ra;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(0)) u_dut32 (
        .i_Clk(clk), .i_Reset(rst), .i_Instruction(inst), .i_ImmSrc(src),
        .i_Tag(tag), .i_Valid(valid), .o_Ready(r32), .i_Flush(flush),
        .o_ImmExt(imm32), .o_Illegal(ill32), .o_Tag(tag32),
        .o_Valid(v32), .i_Ready(rdy));

    imm_gen_stage #(.XLEN(64), .TAG_W(32), .AUTO_DECODE(0)) u_dut64 (
        .i_Clk(clk), .i_Reset(rst), .i_Instruction(inst), .i_ImmSrc(src),
        .i_Tag(tag), .i_Valid(valid), .o_Ready(r64), .i_Flush(flush),
        .o_ImmExt(imm64), .o_Illegal(ill64), .o_Tag(tag64),
        .o_Valid(v64), .i_Ready(rdy));

    imm_gen_stage #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1)) u_auto (
        .i_Clk(clk), .i_Reset(rst), .i_Instruction(inst), .i_ImmSrc(src),
        .i_Tag(tag), .i_Valid(valid), .o_Ready(ra), .i_Flush(flush),
        .o_ImmExt(imma), .o_Illegal(illa), .o_Tag(taga),
        .o_Valid(va), .i_Ready(rdy));

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  src;
        logic [31:0] tag;
    } beat_t;

    beat_t       q[$];
    logic [31:0] delivered[$];
    bit          last_accept;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Immediate value from the format rules, via shifts on a signed word.
    function automatic logic [63:0] ref_imm(input logic [31:0] w, input int t);
        longint x;
        longint s;
        x = longint'($signed(w));
        s = w[31] ? -64'sd1 : 64'sd0;
        case (t)
            0: return 64'(x >>> 20);
            1: return 64'(((x >>> 25) <<< 5) | longint'(w[11:7]));
            2: return 64'((s <<< 12) | (longint'(w[7]) <<< 11)
                        | (longint'(w[30:25]) <<< 5) | (longint'(w[11:8]) <<< 1));
            3: return 64'((x >>> 12) <<< 12);
            4: return 64'((s <<< 20) | (longint'(w[19:12]) <<< 12)
                        | (longint'(w[20]) <<< 11) | (longint'(w[30:21]) <<< 1));
            default: return 64'd0;
        endcase
    endfunction

    function automatic int auto_type(input logic [6:0] op);
        if (op inside {7'h13, 7'h03, 7'h67, 7'h73}) return 0;
        if (op == 7'h23) return 1;
        if (op == 7'h63) return 2;
        if (op inside {7'h37, 7'h17}) return 3;
        if (op == 7'h6F) return 4;
        return 7;
    endfunction

    task automatic compare();
        beat_t       b;
        logic [63:0] e;
        int          ta;
        chk("valid32", 64'(v32), 64'(q.size() > 0));
        chk("valid64", 64'(v64), 64'(q.size() > 0));
        chk("valida", 64'(va), 64'(q.size() > 0));
        chk("ready32", 64'(r32), 64'(q.size() < 2));
        chk("ready64", 64'(r64), 64'(q.size() < 2));
        chk("readya", 64'(ra), 64'(q.size() < 2));
        if (q.size() > 0) begin
            b = q[0];
            e = ref_imm(b.inst, int'(b.src));
            chk("imm32", 64'(imm32), 64'(e[31:0]));
            chk("imm64", imm64, e);
            chk("ill32", 64'(ill32), 64'(b.src > 3'd4));
            chk("ill64", 64'(ill64), 64'(b.src > 3'd4));
            chk("tag32", 64'(tag32), 64'(b.tag));
            chk("tag64", 64'(tag64), 64'(b.tag));
            ta = auto_type(b.inst[6:0]);
            e  = ref_imm(b.inst, ta);
            chk("imma", 64'(imma), 64'(e[31:0]));
            chk("illa", 64'(illa), 64'(ta > 4));
            chk("taga", 64'(taga), 64'(b.tag));
        end
    endtask

    task automatic step();
        bit acc;
        bit xf;
        @(posedge clk);
        acc = valid && (q.size() < 2);
        xf  = (q.size() > 0) && rdy;
        if (rst || flush) begin
            q.delete();
            acc = 1'b0;
        end else begin
            if (xf) begin
                delivered.push_back(q[0].tag);
                void'(q.pop_front());
            end
            if (acc) q.push_back('{inst, src, tag});
        end
        last_accept = acc;
        #1;
        compare();
    endtask

    task automatic check_zero(input string name);
        chk({name, "_imm32"}, 64'(imm32), 64'd0);
        chk({name, "_imm64"}, imm64, 64'd0);
        chk({name, "_imma"}, 64'(imma), 64'd0);
        chk({name, "_ill"}, 64'({ill32, ill64, illa}), 64'd0);
        chk({name, "_tag"}, 64'({tag32, taga}), 64'd0);
        chk({name, "_rdy"}, 64'(r32), 64'd1);
    endtask

    task automatic send(input logic [31:0] w, input logic [2:0] s,
                        input logic [31:0] t);
        inst  = w;
        src   = s;
        tag   = t;
        valid = 1'b1;
        rdy   = 1'b1;
        step();
        valid = 1'b0;
    endtask

    logic [31:0] vi[4]  = '{32'hFFF00093, 32'hFE000EE3, 32'h123450B7, 32'h001000EF};
    logic [2:0]  vs[4]  = '{3'd0, 3'd2, 3'd3, 3'd4};
    logic [63:0] ve[4]  = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                            64'h0000000012345000, 64'h0000000000000800};
    logic [6:0]  ops[11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                             7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    initial begin
        int          k;
        int          c;
        int          low_cnt;
        logic [31:0] r;
        logic [63:0] e;

        rst = 1'b1;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            e = ve[i];
            send(vi[i], vs[i], 32'(i + 1));
            chk("lit_imm32", 64'(imm32), 64'(e[31:0]));
            chk("lit_imm64", imm64, e);
            chk("lit_imma", 64'(imma), 64'(e[31:0]));
            chk("lit_ill32", 64'(ill32), 64'd0);
            step();
            send(vi[i], 3'b111, 32'(i + 11));
            chk("lit_auto_imm", 64'(imma), 64'(e[31:0]));
            chk("lit_auto_ill", 64'(illa), 64'd0);
            chk("lit_src_ill", 64'(ill32), 64'd1);
            chk("lit_src_imm", 64'(imm32), 64'd0);
            step();
        end
        send(32'h002081B3, 3'b111, 32'h33);
        chk("lit_op33_imm", 64'(imma), 64'd0);
        chk("lit_op33_ill", 64'(illa), 64'd1);
        step();

        delivered.delete();
        k       = 1;
        c       = 0;
        low_cnt = 0;
        while (delivered.size() < 5 && c < 40) begin
            c++;
            valid = (k <= 5);
            tag   = 32'(k);
            r     = $urandom();
            inst  = r;
            src   = 3'($urandom_range(0, 4));
            rdy   = !(c >= 2 && c <= 4);
            step();
            if (!r32) low_cnt++;
            if (last_accept) k++;
        end
        valid = 1'b0;
        chk("tags_count", 64'(delivered.size()), 64'd5);
        for (int i = 0; i < 5 && i < delivered.size(); i++)
            chk("tag_order", 64'(delivered[i]), 64'(i + 1));
        chk("ready_low_cycles", 64'(low_cnt), 64'd3);

        delivered.delete();
        rdy   = 1'b0;
        valid = 1'b1;
        tag   = 32'hA1;
        step();
        tag = 32'hA2;
        step();
        chk("full2_ready", 64'(r32), 64'd0);
        flush = 1'b1;
        tag   = 32'hA3;
        step();
        flush = 1'b0;
        valid = 1'b0;
        chk("flush_valid", 64'(v32), 64'd0);
        chk("flush_ready", 64'(r32), 64'd1);
        rdy = 1'b1;
        repeat (3) step();
        chk("flush_none_out", 64'(delivered.size()), 64'd0);

        rdy   = 1'b0;
        valid = 1'b1;
        tag   = 32'hB1;
        step();
        valid = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        check_zero("midreset");
        chk("midreset_valid", 64'(v32), 64'd0);
        send(32'h00500093, 3'd0, 32'hB2);
        repeat (2) step();
        chk("resume_count", 64'(delivered.size()), 64'd1);
        if (delivered.size() > 0)
            chk("resume_tag", 64'(delivered[0]), 64'hB2);

        for (int i = 0; i < 3000; i++) begin
            r     = $urandom();
            inst  = {r[31:7], ops[$urandom_range(0, 10)]};
            src   = 3'($urandom_range(0, 7));
            tag   = $urandom();
            valid = ($urandom_range(0, 3) != 0);
            rdy   = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 40) == 0);
            rst   = ($urandom_range(0, 200) == 0);
            step();
        end
        rst   = 1'b0;
        flush = 1'b0;
        valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
